// File: rtl/axis_uart_rx_packetizer.sv
// Frames the UART RX byte stream into AXIS packets (delimiter / length / idle-timeout close)
// and buffers them in a first-word fall-through FIFO with a per-packet error flag in tuser.
module axis_uart_rx_packetizer #(
  parameter int                   DATA_BITS   = 8,
  parameter int                   FIFO_DEPTH  = 16,
  parameter int                   MAX_LEN     = 64,
  parameter int                   IDLE_CYCLES = 1000,
  parameter int                   DELIM_ENA   = 1,
  parameter logic [DATA_BITS-1:0] DELIM       = 8'h0A
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 parity_err,
  input  logic                 frame_err,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [15:0]          drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int EW = DATA_BITS + 2;
  localparam logic [IW-1:0] IDLE_MAX = (IDLE_CYCLES > 0) ? IW'(IDLE_CYCLES - 1) : '0;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_LEN);

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [DATA_BITS-1:0] stage_data_r, stage_data_s;
  logic                 stage_last_r, stage_last_s;
  logic [CW-1:0]        pkt_cnt_r, pkt_cnt_s, pkt_base_s, pkt_inc_s;
  logic [IW-1:0]        idle_cnt_r, idle_cnt_s;
  logic                 err_acc_r, err_acc_s, err_set_s;
  logic                 parity_q_r;
  logic [15:0]          drop_cnt_r;
  logic                 tready_r;
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [EW-1:0]        mem_r [FIFO_DEPTH];
  logic [EW-1:0]        rd_entry_s, wr_entry_s;
  logic                 accept_s, full_s, empty_s, rd_en_s, space_s, timeout_s;
  logic                 wr_en_s, wr_last_s, load_s, drop_s, close_s;

  assign accept_s  = s_axis_tvalid && tready_r;
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign rd_en_s   = !empty_s && m_axis_tready;
  // A beat leaving this cycle frees a slot, so a full FIFO can still take a write.
  assign space_s   = !full_s || rd_en_s;
  assign timeout_s = (IDLE_CYCLES != 0) && (state_r == S_HOLD) && !stage_last_r &&
                     (idle_cnt_r == IDLE_MAX);
  assign close_s   = wr_en_s && wr_last_s;
  assign err_set_s = (accept_s && frame_err) || (parity_err && !parity_q_r) || drop_s;
  assign wr_entry_s = {wr_last_s & err_acc_r, wr_last_s, stage_data_r};

  // Stage FSM: decide commit, replace, drop or hold for the staged byte.
  always_comb begin
    state_s      = state_r;
    wr_en_s      = 1'b0;
    wr_last_s    = 1'b0;
    load_s       = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      S_EMPTY: begin
        if (accept_s) begin
          load_s  = 1'b1;
          state_s = S_HOLD;
        end else begin
          state_s = S_EMPTY;
        end
      end
      S_HOLD: begin
        if (space_s && (stage_last_r || accept_s || timeout_s)) begin
          wr_en_s   = 1'b1;
          wr_last_s = stage_last_r || timeout_s;
          if (accept_s) begin
            load_s  = 1'b1;
            state_s = S_HOLD;
          end else begin
            state_s = S_EMPTY;
          end
        end else if (accept_s) begin
          drop_s  = 1'b1;
          state_s = S_HOLD;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: state_s = S_EMPTY;
    endcase
  end

  // Packet length, last flag, idle counter and error accumulator next-state.
  always_comb begin
    stage_data_s = stage_data_r;
    stage_last_s = stage_last_r;
    pkt_base_s   = close_s ? {CW{1'b0}} : pkt_cnt_r;
    pkt_inc_s    = pkt_base_s + CW'(1);
    pkt_cnt_s    = pkt_base_s;
    idle_cnt_s   = idle_cnt_r;
    err_acc_s    = (close_s ? 1'b0 : err_acc_r) | err_set_s;
    if (load_s) begin
      stage_data_s = s_axis_tdata;
      pkt_cnt_s    = pkt_inc_s;
      stage_last_s = ((DELIM_ENA != 0) && (s_axis_tdata == DELIM)) || (pkt_inc_s == MAX_CNT);
    end else begin
      pkt_cnt_s    = pkt_base_s;
    end
    if (accept_s || close_s) begin
      idle_cnt_s = {IW{1'b0}};
    end else if ((IDLE_CYCLES != 0) && (state_r == S_HOLD) && !stage_last_r &&
                 (idle_cnt_r != IDLE_MAX)) begin
      idle_cnt_s = idle_cnt_r + IW'(1);
    end else begin
      idle_cnt_s = idle_cnt_r;
    end
  end

  // Control state, counters and FIFO pointers.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_r      <= S_EMPTY;
      stage_data_r <= {DATA_BITS{1'b0}};
      stage_last_r <= 1'b0;
      pkt_cnt_r    <= {CW{1'b0}};
      idle_cnt_r   <= {IW{1'b0}};
      err_acc_r    <= 1'b0;
      parity_q_r   <= 1'b0;
      drop_cnt_r   <= 16'h0000;
      tready_r     <= 1'b0;
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
    end else begin
      state_r      <= state_s;
      stage_data_r <= stage_data_s;
      stage_last_r <= stage_last_s;
      pkt_cnt_r    <= pkt_cnt_s;
      idle_cnt_r   <= idle_cnt_s;
      err_acc_r    <= err_acc_s;
      parity_q_r   <= parity_err;
      tready_r     <= 1'b1;
      if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care until the write pointer passes them.
  always_ff @(posedge aclk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_entry_s;
  end

  assign rd_entry_s    = mem_r[rd_ptr_r[AW-1:0]];
  assign s_axis_tready = tready_r;
  assign drop_cnt      = drop_cnt_r;
  assign m_axis_tvalid = !empty_s;
  assign m_axis_tdata  = empty_s ? {DATA_BITS{1'b0}} : rd_entry_s[DATA_BITS-1:0];
  assign m_axis_tlast  = !empty_s && rd_entry_s[DATA_BITS];
  assign m_axis_tuser  = !empty_s && rd_entry_s[DATA_BITS+1] && rd_entry_s[DATA_BITS];

endmodule

// File: tb/tb_axis_uart_rx_packetizer.sv
// Scoreboard bench for axis_uart_rx_packetizer: four parameterisations share the input bus,
// one is selected per scenario, and a negedge monitor pops expected beats on each transfer.
module tb_axis_uart_rx_packetizer;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       arstn;
  logic [7:0] s_data;
  logic       s_valid, parity_err, frame_err, m_ready;
  int         sel;

  logic        s_valid_v [4];
  logic        s_ready   [4];
  logic [7:0]  m_data    [4];
  logic        m_valid   [4];
  logic        m_last    [4];
  logic        m_user    [4];
  logic [15:0] drop_cnt  [4];

  always_comb begin
    for (int i = 0; i < 4; i++) s_valid_v[i] = s_valid && (sel == i);
  end

  axis_uart_rx_packetizer u_a (
    .aclk(aclk), .arstn(arstn), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid_v[0]),
    .s_axis_tready(s_ready[0]), .parity_err(parity_err), .frame_err(frame_err),
    .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last[0]), .m_axis_tuser(m_user[0]), .drop_cnt(drop_cnt[0]));

  axis_uart_rx_packetizer #(.DELIM_ENA(0), .IDLE_CYCLES(50)) u_b (
    .aclk(aclk), .arstn(arstn), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid_v[1]),
    .s_axis_tready(s_ready[1]), .parity_err(parity_err), .frame_err(frame_err),
    .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last[1]), .m_axis_tuser(m_user[1]), .drop_cnt(drop_cnt[1]));

  axis_uart_rx_packetizer #(.MAX_LEN(4), .IDLE_CYCLES(50)) u_c (
    .aclk(aclk), .arstn(arstn), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid_v[2]),
    .s_axis_tready(s_ready[2]), .parity_err(parity_err), .frame_err(frame_err),
    .m_axis_tdata(m_data[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last[2]), .m_axis_tuser(m_user[2]), .drop_cnt(drop_cnt[2]));

  axis_uart_rx_packetizer #(.MAX_LEN(1), .IDLE_CYCLES(0)) u_d (
    .aclk(aclk), .arstn(arstn), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid_v[3]),
    .s_axis_tready(s_ready[3]), .parity_err(parity_err), .frame_err(frame_err),
    .m_axis_tdata(m_data[3]), .m_axis_tvalid(m_valid[3]), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last[3]), .m_axis_tuser(m_user[3]), .drop_cnt(drop_cnt[3]));

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t exp_q [$];
  beat_t mon_e;
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    last_beat_cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Scoreboard: every accepted output beat must match the head of the expected queue.
  always @(negedge aclk) begin
    if (arstn === 1'b1 && m_valid[sel] === 1'b1 && m_ready === 1'b1) begin
      n_vec++;
      last_beat_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data=%h last=%b user=%b, required no beat",
                 m_data[sel], m_last[sel], m_user[sel]);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_data[sel], m_last[sel], m_user[sel]} !== {mon_e.data, mon_e.last, mon_e.user}) begin
          n_err++;
          $display("FAIL beat: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                   m_data[sel], m_last[sel], m_user[sel], mon_e.data, mon_e.last, mon_e.user);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b.data = d; b.last = l; b.user = u;
    exp_q.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fe, output int acc);
    @(posedge aclk); #1;
    s_data = d; frame_err = fe; s_valid = 1'b1; acc = cyc;
    @(posedge aclk); #1;
    s_valid = 1'b0; frame_err = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge aclk); #2;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (8) @(posedge aclk);
  endtask

  task automatic test_reset();
    sel = 0; s_data = 8'h00; s_valid = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
    m_ready = 1'b0; arstn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_vec++;
    if ({m_valid[0], m_last[0], m_user[0], m_data[0], drop_cnt[0], s_ready[0]} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b last=%b user=%b data=%h drop=%h ready=%b, required all 0",
               m_valid[0], m_last[0], m_user[0], m_data[0], drop_cnt[0], s_ready[0]);
    end
    @(posedge aclk); #1;
    arstn = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (s_ready[i] !== 1'b1 || m_valid[i] !== 1'b0) begin
        n_err++;
        $display("FAIL out_of_reset[%0d]: got ready=%b valid=%b, required ready=1 valid=0",
                 i, s_ready[i], m_valid[i]);
      end
    end
  endtask

  task automatic test_delim();
    int acc;
    bit ok;
    sel = 0; m_ready = 1'b1;
    push_exp(8'h41, 1'b0, 1'b0);
    push_exp(8'h42, 1'b0, 1'b0);
    push_exp(8'h0A, 1'b1, 1'b0);
    send_byte(8'h41, 1'b0, acc);
    repeat (20) @(posedge aclk);
    send_byte(8'h42, 1'b0, acc);
    repeat (20) @(posedge aclk);
    send_byte(8'h0A, 1'b0, acc);
    wait_drain(100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL delim_drain: got %0d beats pending, required 0", exp_q.size()); end
    n_vec++;
    if (last_beat_cyc - acc !== 2) begin
      n_err++;
      $display("FAIL delim_latency: got %0d cycles, required 2", last_beat_cyc - acc);
    end
  endtask

  task automatic test_timeout();
    int acc;
    bit ok;
    sel = 1; m_ready = 1'b1;
    push_exp(8'h01, 1'b0, 1'b0);
    push_exp(8'h02, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, acc);
    repeat (5) @(posedge aclk);
    send_byte(8'h02, 1'b0, acc);
    wait_drain(200, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL timeout_drain: got %0d beats pending, required 0", exp_q.size()); end
    n_vec++;
    if (last_beat_cyc - acc !== 51) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles, required 51", last_beat_cyc - acc);
    end
  endtask

  task automatic test_max_len();
    int acc;
    bit ok;
    sel = 2; m_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_exp(8'h11 + 8'(i), (i == 3 || i == 7 || i == 8), 1'b0);
    @(posedge aclk); #1;
    for (int i = 0; i < 9; i++) begin
      s_data = 8'h11 + 8'(i); s_valid = 1'b1; acc = cyc;
      @(posedge aclk); #1;
    end
    s_valid = 1'b0;
    wait_drain(300, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL maxlen_drain: got %0d beats pending, required 0", exp_q.size()); end
    n_vec++;
    if (last_beat_cyc - acc !== 51) begin
      n_err++;
      $display("FAIL maxlen_tail_latency: got %0d cycles, required 51", last_beat_cyc - acc);
    end
  endtask

  task automatic test_errors();
    int acc;
    bit ok;
    sel = 0; m_ready = 1'b1;
    push_exp(8'h31, 1'b0, 1'b0);
    push_exp(8'h32, 1'b0, 1'b0);
    push_exp(8'h0A, 1'b1, 1'b1);
    push_exp(8'h33, 1'b0, 1'b0);
    push_exp(8'h0A, 1'b1, 1'b0);
    push_exp(8'h34, 1'b0, 1'b0);
    push_exp(8'h0A, 1'b1, 1'b1);
    send_byte(8'h31, 1'b0, acc);
    send_byte(8'h32, 1'b1, acc);
    send_byte(8'h0A, 1'b0, acc);
    repeat (4) @(posedge aclk);
    send_byte(8'h33, 1'b0, acc);
    send_byte(8'h0A, 1'b0, acc);
    repeat (4) @(posedge aclk);
    send_byte(8'h34, 1'b0, acc);
    @(posedge aclk); #1 parity_err = 1'b1;
    repeat (3) @(posedge aclk);
    #1 parity_err = 1'b0;
    send_byte(8'h0A, 1'b0, acc);
    wait_drain(100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL errors_drain: got %0d beats pending, required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    int acc;
    bit ok;
    logic [7:0] head;
    sel = 0; m_ready = 1'b0;
    for (int i = 0; i < 17; i++) push_exp(8'h40 + 8'(i), (i == 16), (i == 16));
    for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i), 1'b0, acc);
    @(negedge aclk);
    n_vec++;
    if (drop_cnt[0] !== 16'd3) begin
      n_err++;
      $display("FAIL drop_cnt: got %0d, required 3", drop_cnt[0]);
    end
    head = m_data[0];
    repeat (5) @(negedge aclk);
    n_vec++;
    if (m_valid[0] !== 1'b1 || m_data[0] !== 8'h40 || head !== 8'h40) begin
      n_err++;
      $display("FAIL stall_hold: got valid=%b data=%h (first %h), required valid=1 data=40",
               m_valid[0], m_data[0], head);
    end
    @(posedge aclk); #1 m_ready = 1'b1;
    wait_drain(1500, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL overflow_drain: got %0d beats pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    sel = 0; m_ready = 1'b0;
    send_byte(8'h61, 1'b1, acc);
    send_byte(8'h62, 1'b0, acc);
    @(posedge aclk); #1 arstn = 1'b0;
    @(posedge aclk); #1 arstn = 1'b1;
    @(negedge aclk);
    n_vec++;
    if (m_valid[0] !== 1'b0 || drop_cnt[0] !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%b drop=%0d, required valid=0 drop=0", m_valid[0], drop_cnt[0]);
    end
    repeat (3) @(posedge aclk);
    #1 m_ready = 1'b1;
    push_exp(8'h71, 1'b0, 1'b0);
    push_exp(8'h0A, 1'b1, 1'b0);
    send_byte(8'h71, 1'b0, acc);
    send_byte(8'h0A, 1'b0, acc);
    wait_drain(100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL reset_mid_drain: got %0d beats pending, required 0", exp_q.size()); end
  endtask

  task automatic test_max_len_one();
    int acc;
    bit ok;
    sel = 3; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(8'h21 + 8'(i), 1'b1, 1'b0);
      send_byte(8'h21 + 8'(i), 1'b0, acc);
    end
    wait_drain(100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL len1_drain: got %0d beats pending, required 0", exp_q.size()); end
    n_vec++;
    if (last_beat_cyc - acc !== 2) begin
      n_err++;
      $display("FAIL len1_latency: got %0d cycles, required 2", last_beat_cyc - acc);
    end
  endtask

  initial begin
    test_reset();
    test_delim();
    test_timeout();
    test_max_len();
    test_errors();
    test_overflow();
    test_reset_mid();
    test_max_len_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
